// File: rtl/fifo_drain_pkg.sv
// Shared defaults and helpers for the FIFO drain block and its elastic buffer.
// The pointer width of the buffer is derived from its depth with clog2().
package fifo_drain_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/drain_buf.sv
// Flip-flop circular queue that catches FIFO words one cycle after each pop
// and presents the oldest entry to the downstream side.
module drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [PTR_W:0]   o_occ
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_occ;

    // Storage is cleared on reset so the head reads zero while nothing is held.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_rptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_drain.sv
// Pops a read-side FIFO into a small elastic buffer and streams it downstream
// with valid/ready, counting every delivered word.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             i_drain_en,
    input  logic             i_rempty,
    output logic             o_rinc,
    input  logic [WIDTH-1:0] i_rdata,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready,
    output logic [CNT_W-1:0] o_out_cnt,
    output logic             o_busy
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W+1:0] CREDIT_LIMIT = (PTR_W+2)'(DEPTH);

    logic             r_inflight;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;

    logic [PTR_W:0]   w_occ;
    logic [PTR_W+1:0] w_credit;
    logic [WIDTH-1:0] w_head;
    logic             w_pop_taken;
    logic             w_xfer;

    // Credits count buffered words plus the one still on its way from the FIFO,
    // so a pop is only issued when a slot is guaranteed; out_ready never enters here.
    assign w_credit    = {1'b0, w_occ} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign o_rinc      = r_armed & i_drain_en & ~i_rempty & (w_credit < CREDIT_LIMIT);
    assign w_pop_taken = o_rinc & ~i_rempty;
    assign w_xfer      = o_out_valid & i_out_ready;

    // r_armed holds off the first pop until one clock edge has passed after reset.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_inflight <= w_pop_taken;
            r_armed    <= 1'b1;
            if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    drain_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .rclk        (rclk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (i_rdata),
        .i_pop       (w_xfer),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign o_out_valid = (w_occ != '0);
    assign o_out_data  = w_head;
    assign o_out_cnt   = r_cnt;
    assign o_busy      = o_out_valid | r_inflight;

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a behavioural read-side FIFO feeds two DUT
// copies (16-bit and 4-bit counters) and a scoreboard tracks pop order.
module tb_fifo_drain;

    localparam int DEPTH = 4;

    logic        rclk = 1'b0;
    logic        rstN = 1'b1;
    logic        drainEn;
    logic        outReady;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc, rinc4;
    logic        outValid, outValid4;
    logic [7:0]  outData, outData4;
    logic [15:0] outCnt;
    logic [3:0]  outCnt4;
    logic        busy, busy4;

    logic [7:0]  fifoMem [0:255];
    int          rdIdx = 0;
    int          wrIdx = 0;

    logic [7:0]  expQ [$];
    int          outstanding;
    int          popCount;
    int          total = 0;
    int          bad = 0;

    always #5 rclk = ~rclk;

    fifo_drain #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .rclk        (rclk),
        .rst_n       (rstN),
        .i_drain_en  (drainEn),
        .i_rempty    (rempty),
        .o_rinc      (rinc),
        .i_rdata     (rdata),
        .o_out_valid (outValid),
        .o_out_data  (outData),
        .i_out_ready (outReady),
        .o_out_cnt   (outCnt),
        .o_busy      (busy)
    );

    fifo_drain #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
        .rclk        (rclk),
        .rst_n       (rstN),
        .i_drain_en  (drainEn),
        .i_rempty    (rempty),
        .o_rinc      (rinc4),
        .i_rdata     (rdata),
        .o_out_valid (outValid4),
        .o_out_data  (outData4),
        .i_out_ready (outReady),
        .o_out_cnt   (outCnt4),
        .o_busy      (busy4)
    );

    // Behavioural FIFO: registered read data, contents discarded by reset.
    assign rempty = (rdIdx == wrIdx);

    always @(posedge rclk or negedge rstN) begin
        if (!rstN) begin
            rdIdx <= wrIdx;
            rdata <= 8'h00;
        end else if (rinc && !rempty) begin
            rdata <= fifoMem[rdIdx];
            rdIdx <= rdIdx + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input logic [7:0] w);
        fifoMem[wrIdx] = w;
        wrIdx++;
    endtask

    // Drive inputs at the falling edge, sample the handshakes, then advance one cycle.
    task automatic applyStimulus(input logic drain, input logic ready);
        logic       popNow;
        logic       xferNow;
        logic [7:0] word;
        logic [7:0] expWord;
        drainEn = drain;
        outReady = ready;
        #1;
        popNow = rinc && !rempty;
        xferNow = outValid && outReady;
        word = fifoMem[rdIdx];
        if (xferNow) begin
            expWord = (expQ.size() != 0) ? expQ.pop_front() : 8'hxx;
            checkOutput("order", {24'b0, outData}, {24'b0, expWord});
        end
        if (popNow) begin
            checkOutput("creditLimit", {31'b0, outstanding < DEPTH}, 32'd1);
            expQ.push_back(word);
            popCount++;
        end
        outstanding = outstanding + int'(popNow) - int'(xferNow);
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        drainEn = 1'b0;
        outReady = 1'b0;
        expQ.delete();
        outstanding = 0;
        popCount = 0;
        repeat (2) @(negedge rclk);
        rstN = 1'b1;
        @(posedge rclk);
        @(negedge rclk);
    endtask

    initial begin
        drainEn = 1'b0;
        outReady = 1'b0;
        outstanding = 0;
        popCount = 0;
        rstN = 1'b0;
        repeat (2) @(negedge rclk);

        checkOutput("rstRinc", {31'b0, rinc}, 32'd0);
        checkOutput("rstValid", {31'b0, outValid}, 32'd0);
        checkOutput("rstData", {24'b0, outData}, 32'h0);
        checkOutput("rstCnt", {16'b0, outCnt}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstAll4", {28'b0, rinc4, outValid4, busy4, |outData4}, 32'd0);

        // First pop waits for the first clock edge after release.
        pushWord(8'hA1);
        pushWord(8'hA2);
        drainEn = 1'b1;
        rstN = 1'b1;
        #1;
        checkOutput("rincAtRelease", {31'b0, rinc}, 32'd0);
        @(negedge rclk);
        checkOutput("rincAfterEdge", {31'b0, rinc}, 32'd1);

        // Five preloaded words, full throughput, first word two cycles after pop.
        applyReset();
        for (int i = 0; i < 5; i++) pushWord(8'h11 + 8'(i));
        applyStimulus(1'b1, 1'b1);
        checkOutput("latValid", {31'b0, outValid}, 32'd0);
        checkOutput("latBusy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("streamValid", {31'b0, outValid}, 32'd1);
            checkOutput("streamData", {24'b0, outData}, 32'h11 + 32'(i));
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("streamEndValid", {31'b0, outValid}, 32'd0);
        checkOutput("streamEndBusy", {31'b0, busy}, 32'd0);
        checkOutput("streamCnt", {16'b0, outCnt}, 32'd5);

        // Downstream stalled: only DEPTH pops, head word held.
        applyReset();
        for (int i = 0; i < 20; i++) pushWord(8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("stallPops", popCount, 32'd4);
        checkOutput("stallRinc", {31'b0, rinc}, 32'd0);
        checkOutput("stallValid", {31'b0, outValid}, 32'd1);
        checkOutput("stallData", {24'b0, outData}, 32'h40);
        for (int i = 0; i < 20 && busy; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("stallDrainBusy", {31'b0, busy}, 32'd0);
        checkOutput("stallDrainCnt", {16'b0, outCnt}, 32'd4);
        checkOutput("stallDrainQ", expQ.size(), 32'd0);

        // Toggling ready with 20 words.
        applyReset();
        for (int i = 0; i < 20; i++) pushWord(8'(i));
        for (int i = 0; i < 200 && outCnt != 16'd20; i++) applyStimulus(1'b1, (i % 2) == 0);
        checkOutput("toggleCnt", {16'b0, outCnt}, 32'd20);
        checkOutput("togglePops", popCount, 32'd20);
        checkOutput("toggleQ", expQ.size(), 32'd0);
        checkOutput("toggleBusy", {31'b0, busy}, 32'd0);
        checkOutput("toggleCnt4", {28'b0, outCnt4}, 32'd4);

        // drain_en dropped right after one pop.
        applyReset();
        pushWord(8'h61);
        pushWord(8'h62);
        pushWord(8'h63);
        applyStimulus(1'b1, 1'b1);
        drainEn = 1'b0;
        #1;
        checkOutput("dropRinc", {31'b0, rinc}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("dropRincHeld", {31'b0, rinc}, 32'd0);
        end
        checkOutput("dropCnt", {16'b0, outCnt}, 32'd1);
        checkOutput("dropBusy", {31'b0, busy}, 32'd0);
        drainEn = 1'b1;
        #1;
        checkOutput("dropResume", {31'b0, rinc}, 32'd1);

        // Asynchronous reset with three words buffered.
        applyReset();
        for (int i = 0; i < 5; i++) pushWord(8'h71 + 8'(i));
        for (int i = 0; i < 20 && outCnt != 16'd2; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("preRstCnt", {16'b0, outCnt}, 32'd2);
        checkOutput("preRstValid", {31'b0, outValid}, 32'd1);
        checkOutput("preRstData", {24'b0, outData}, 32'h73);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncValid", {31'b0, outValid}, 32'd0);
        checkOutput("asyncCnt", {16'b0, outCnt}, 32'd0);
        checkOutput("asyncBusy", {31'b0, busy}, 32'd0);
        checkOutput("asyncData", {24'b0, outData}, 32'h0);
        checkOutput("asyncRinc", {31'b0, rinc}, 32'd0);

        // Narrow counter wraps after 16.
        applyReset();
        for (int i = 0; i < 17; i++) pushWord(8'h80 + 8'(i));
        for (int i = 0; i < 100 && outCnt != 16'd17; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("wrapCnt16", {16'b0, outCnt}, 32'd17);
        checkOutput("wrapCnt4", {28'b0, outCnt4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter WIDTH, default 8, data word width (equals FIFO data width).
REQ-002 Parameter DEPTH, default 4, internal buffer entries (power of two, >=2).
REQ-003 Parameter CNT_W, default 16, width of delivered-word counter.
REQ-004 rclk  input  1  read-domain clock; all logic on posedge rclk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 drain_en  input  1  high = block may pop the FIFO; low = no new pops.
REQ-007 rempty  input  1  FIFO empty flag, already rclk-synchronous.
REQ-008 rinc  output  1  FIFO pop request.
REQ-009 rdata  input  WIDTH  FIFO read data, registered inside the FIFO.
REQ-010 out_valid  output  1  downstream data valid.
REQ-011 out_data  output  WIDTH  downstream data.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_cnt  output  CNT_W  count of words delivered downstream.
REQ-014 busy  output  1  high while buffer non-empty or pop in flight.

Function
REQ-015 FIFO contract: pop = rinc&!rempty in cycle t; popped word is on rdata in cycle t+1 and held until the next pop.
REQ-016 rinc SHALL be 1 only when drain_en=1, rempty=0, and (occ + inflight) < DEPTH.
REQ-017 occ = buffered entries; inflight = 1 in cycle t+1 after a pop in t, else 0.
REQ-018 rinc SHALL have no combinational path from out_ready or out_valid.
REQ-019 In cycle t+1 after a pop, rdata SHALL be written into the buffer tail; exactly one write per pop.
REQ-020 Buffer is a circular DEPTH-entry queue; read/write pointers wrap from DEPTH-1 to 0.
REQ-021 out_valid = (occ != 0); out_data = head entry; both stable while out_valid&!out_ready.
REQ-022 Transfer = out_valid&out_ready; advances the head pointer and increments out_cnt by 1.
REQ-023 Simultaneous write and transfer in one cycle SHALL leave occ unchanged; both pointers advance.
REQ-024 Write into a full buffer SHALL never occur (guaranteed by REQ-016); a bench assertion checks this.
REQ-025 out_cnt wraps modulo 2^CNT_W with no saturation or flag.
REQ-026 With drain_en=1, FIFO never empty and out_ready=1, steady-state throughput SHALL be one word per cycle.
REQ-027 First word latency: pop in cycle t -> out_valid=1 in cycle t+2 (write at t+1 edge, registered head).
REQ-028 drain_en deassertion SHALL stop new pops next cycle; in-flight word and buffered words still delivered.
REQ-029 busy = (occ != 0) | inflight.
REQ-030 Data order out SHALL equal FIFO pop order; no duplication, no loss.

Reset
REQ-031 rst_n low: rinc=0, out_valid=0, out_data=0, out_cnt=0, busy=0, pointers=0, occ=0, inflight=0.
REQ-032 Reset mid-operation discards buffered and in-flight words; the FIFO is reset by the same rst_n.
REQ-033 Reset deassertion: first rinc no earlier than the first rclk edge after release.

Structure
REQ-034 Shared package holds WIDTH/DEPTH defaults and the ceil-log2 helper used for pointer width.
REQ-035 One sub-module, drain_buf: DEPTH-entry circular queue with push/pop/occ; fifo_drain holds the pop/credit logic and out_cnt.
REQ-036 Buffer storage is flip-flops; no SRAM macro.

Verification
REQ-037 Preload 5 words 0x11..0x15, drain_en=1, out_ready=1 -> out_data 0x11..0x15 on consecutive cycles, first at pop+2, out_cnt=5, busy=0 after.
REQ-038 Continuous FIFO supply, out_ready=0 for 10 cycles -> exactly DEPTH(4) pops, rinc=0 afterwards, out_data held at first word.
REQ-039 out_ready toggling 1,0,1,0 with 20 words 0x00..0x13 -> all 20 delivered in order, no overflow assertion fires.
REQ-040 drain_en dropped the cycle after a pop -> that word still delivered, no further rinc until drain_en=1.
REQ-041 rst_n pulsed low with 3 words buffered -> out_valid=0, out_cnt=0 immediately, asynchronously.
REQ-042 CNT_W=4, 17 words delivered -> out_cnt reads 1 (wrap).
